// File: rtl/pl_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush,
// and data-memory wait handling with a timeout error state.
module pl_hazard_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   input  logic [4:0]  Rs1E,
   input  logic [4:0]  Rs2E,
   input  logic [4:0]  RdE,
   input  logic        ResultSrcE0,
   input  logic        PCSrcE,
   input  logic [4:0]  RdM,
   input  logic [4:0]  RdW,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic        MemAccessM,
   input  logic        dmem_ack,
   output logic        dmem_req,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        StallW,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushW,
   output logic        mem_timeout,
   output logic [15:0] stall_cycles
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned SC_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d, wait_cnt_inc;
   logic               mem_timeout_q, mem_timeout_d;
   logic [SC_W-1:0]    stall_cnt_q, stall_cnt_d;
   logic               mem_busy;
   logic               lw_stall;

   // Forward select for one Execute source: Memory beats Writeback, x0 never forwards.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rd_m, input logic wr_m,
                                          input logic [4:0] rd_w, input logic wr_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         sel = 2'b10;
      end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   // Next-state logic for the memory-wait FSM, its wait counter and the stall counter.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      wait_cnt_inc  = wait_cnt_q + CNT_W'(1);
      unique case (state_q)
         ST_IDLE: begin
            if (MemAccessM && !dmem_ack) begin
               state_d    = ST_WAIT;
               wait_cnt_d = '0;
            end
         end
         ST_WAIT: begin
            if (dmem_ack) begin
               state_d = ST_IDLE;
            end else if (wait_cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
               state_d = ST_ERR;
            end else begin
               wait_cnt_d = wait_cnt_inc;
            end
         end
         ST_ERR: begin
            state_d = ST_ERR;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      mem_timeout_d = (state_d == ST_ERR);
      stall_cnt_d   = (StallF && (stall_cnt_q != '1)) ? stall_cnt_q + SC_W'(1) : stall_cnt_q;
   end

   // Combinational hazard outputs; reset forces a safe idle pipeline with flushes asserted.
   always_comb begin
      dmem_req  = 1'b0;
      mem_busy  = 1'b0;
      lw_stall  = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      StallW    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      if (!rst_n) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
         FlushW = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: dmem_req = MemAccessM;
            ST_WAIT: dmem_req = 1'b1;
            default: dmem_req = 1'b0;
         endcase
         mem_busy  = (dmem_req && !dmem_ack) || (state_q == ST_ERR);
         lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
         ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
         ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
         if (mem_busy) begin
            // Freeze F..M and push a bubble into Writeback; E/D events wait behind the hold.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushD = PCSrcE;
            FlushE = lw_stall || PCSrcE;
         end
      end
   end

   // State, counters and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
         stall_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign mem_timeout  = mem_timeout_q;
   assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Self-checking bench for pl_hazard_ctrl: directed scenarios plus randomized
// traffic, all checked against a cycle-level behavioural model.
module tb_pl_hazard_ctrl;

   localparam int unsigned TIMEOUT = 255;

   logic        clk;
   logic        rst_n;
   logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic        ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemAccessM, dmem_ack;
   logic        dmem_req;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        StallF, StallD, StallE, StallM, StallW;
   logic        FlushD, FlushE, FlushW;
   logic        mem_timeout;
   logic [15:0] stall_cycles;

   int total = 0;
   int bad   = 0;

   // behavioural model: an outstanding access, its age, error flag, stall count
   bit          m_pend = 0;
   int          m_age  = 0;
   bit          m_err  = 0;
   int          m_sc   = 0;
   logic [12:0] m_exp;

   pl_hazard_ctrl #(.TIMEOUT_CYC(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
      .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemAccessM(MemAccessM), .dmem_ack(dmem_ack),
      .dmem_req(dmem_req), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   // expected {dmem_req, FAE, FBE, StallF,D,E,M,W, FlushD,E,W}
   function automatic logic [12:0] ref_comb();
      logic req, busy, lw;
      if (!rst_n) return 13'b0_00_00_00000_111;
      req  = m_err ? 1'b0 : (m_pend ? 1'b1 : MemAccessM);
      busy = m_err || (req && !dmem_ack);
      lw   = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      if (busy)
         return {req, ref_fwd(Rs1E), ref_fwd(Rs2E), 5'b11110, 3'b001};
      return {req, ref_fwd(Rs1E), ref_fwd(Rs2E), lw, lw, 3'b000, PCSrcE, lw | PCSrcE, 1'b0};
   endfunction

   task automatic clear_inputs();
      rst_n = 1'b1;
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
      MemAccessM = 0; dmem_ack = 0;
   endtask

   // settle inputs, compare combinational outputs against the model
   task automatic eval_comb(input string name);
      logic [12:0] got;
      #1;
      m_exp = ref_comb();
      got = {dmem_req, ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
             FlushD, FlushE, FlushW};
      total++;
      if (got !== m_exp) begin
         bad++;
         $display("FAIL %s comb: got %b expected %b", name, got, m_exp);
      end
   endtask

   // clock edge, advance model, compare registered outputs, return to negedge
   task automatic clk_adv(input string name);
      @(posedge clk);
      if (!rst_n) begin
         m_pend = 0; m_age = 0; m_err = 0; m_sc = 0;
      end else begin
         if (m_exp[7] && m_sc < 65535) m_sc++;
         if (!m_err) begin
            if (m_pend) begin
               if (dmem_ack) m_pend = 0;
               else begin
                  m_age++;
                  if (m_age >= TIMEOUT) begin m_err = 1; m_pend = 0; end
               end
            end else if (MemAccessM && !dmem_ack) begin
               m_pend = 1; m_age = 0;
            end
         end
      end
      #1;
      total++;
      if (mem_timeout !== m_err) begin
         bad++;
         $display("FAIL %s mem_timeout: got %b expected %b", name, mem_timeout, m_err);
      end
      total++;
      if (stall_cycles !== 16'(m_sc)) begin
         bad++;
         $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cycles, m_sc);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0; MemAccessM = 1; RegWriteM = 1; RdM = 3; Rs1E = 3; PCSrcE = 1;
      eval_comb("reset");
      total++;
      if ({dmem_req, StallF, FlushD, FlushE, FlushW, ForwardAE} !== 7'b0011100) begin
         bad++;
         $display("FAIL reset_outputs: got %b expected 0011100",
                  {dmem_req, StallF, FlushD, FlushE, FlushW, ForwardAE});
      end
      clk_adv("reset");
      total++;
      if (stall_cycles !== 16'd0 || mem_timeout !== 1'b0) begin
         bad++;
         $display("FAIL reset_regs: got sc=%0d to=%b expected 0 0", stall_cycles, mem_timeout);
      end
      clear_inputs();
   endtask

   task automatic test_same_cycle_ack();
      clear_inputs();
      MemAccessM = 1; dmem_ack = 1;
      eval_comb("same_ack");
      total++;
      if (dmem_req !== 1'b1 || StallF !== 1'b0 || FlushW !== 1'b0) begin
         bad++;
         $display("FAIL same_ack: got req=%b stallF=%b flushW=%b expected 1 0 0",
                  dmem_req, StallF, FlushW);
      end
      clk_adv("same_ack");
      MemAccessM = 0; dmem_ack = 0;
      eval_comb("same_ack_idle");
      total++;
      if (dmem_req !== 1'b0) begin
         bad++;
         $display("FAIL same_ack_idle: got req=%b expected 0", dmem_req);
      end
      clk_adv("same_ack_idle");
   endtask

   task automatic test_mem_wait3();
      int sc0, nst;
      clear_inputs();
      sc0 = int'(stall_cycles);
      nst = 0;
      for (int c = 0; c < 4; c++) begin
         MemAccessM = (c == 0);
         dmem_ack   = (c == 3);
         eval_comb("wait3");
         if (StallF && StallD && StallE && StallM && !StallW && FlushW) nst++;
         clk_adv("wait3");
      end
      total++;
      if (nst != 3) begin
         bad++;
         $display("FAIL wait3_stall_len: got %0d expected 3", nst);
      end
      total++;
      if (int'(stall_cycles) - sc0 != 3) begin
         bad++;
         $display("FAIL wait3_stall_cycles: got %0d expected 3", int'(stall_cycles) - sc0);
      end
      clear_inputs();
      eval_comb("wait3_idle");
      total++;
      if (dmem_req !== 1'b0 || StallF !== 1'b0) begin
         bad++;
         $display("FAIL wait3_idle: got req=%b stallF=%b expected 0 0", dmem_req, StallF);
      end
      clk_adv("wait3_idle");
   endtask

   task automatic test_lw_stall();
      clear_inputs();
      ResultSrcE0 = 1; RdE = 5; Rs2D = 5; Rs1D = 2;
      eval_comb("lw_hit");
      total++;
      if ({StallF, StallD, FlushE, StallE, FlushD} !== 5'b11100) begin
         bad++;
         $display("FAIL lw_hit: got %b expected 11100", {StallF, StallD, FlushE, StallE, FlushD});
      end
      clk_adv("lw_hit");
      ResultSrcE0 = 0; RdE = 0;
      eval_comb("lw_bubble");
      total++;
      if (StallF !== 1'b0 || FlushE !== 1'b0) begin
         bad++;
         $display("FAIL lw_bubble: got stallF=%b flushE=%b expected 0 0", StallF, FlushE);
      end
      clk_adv("lw_bubble");
      ResultSrcE0 = 1; RdE = 0; Rs2D = 0;
      eval_comb("lw_x0");
      total++;
      if (StallF !== 1'b0 || StallD !== 1'b0 || FlushE !== 1'b0) begin
         bad++;
         $display("FAIL lw_x0: got %b expected 000", {StallF, StallD, FlushE});
      end
      clk_adv("lw_x0");
      clear_inputs();
   endtask

   task automatic test_branch_in_wait();
      clear_inputs();
      PCSrcE = 1;
      for (int c = 0; c < 4; c++) begin
         MemAccessM = (c == 0);
         dmem_ack   = (c == 3);
         eval_comb("br_wait");
         total++;
         if (c < 3 && (FlushD !== 1'b0 || FlushE !== 1'b0)) begin
            bad++;
            $display("FAIL br_wait_masked: cycle %0d got %b%b expected 00", c, FlushD, FlushE);
         end else if (c == 3 && (FlushD !== 1'b1 || FlushE !== 1'b1 || StallF !== 1'b0)) begin
            bad++;
            $display("FAIL br_wait_release: got flushD/E=%b%b stallF=%b expected 11 0",
                     FlushD, FlushE, StallF);
         end
         clk_adv("br_wait");
      end
      // branch together with a load-use hazard
      clear_inputs();
      PCSrcE = 1; ResultSrcE0 = 1; RdE = 9; Rs1D = 9;
      eval_comb("br_lw");
      total++;
      if ({FlushD, FlushE, StallF, StallD} !== 4'b1111) begin
         bad++;
         $display("FAIL br_lw: got %b expected 1111", {FlushD, FlushE, StallF, StallD});
      end
      clk_adv("br_lw");
      clear_inputs();
   endtask

   task automatic test_forward();
      clear_inputs();
      RdM = 7; RdW = 7; Rs1E = 7; Rs2E = 7; RegWriteM = 1; RegWriteW = 1;
      eval_comb("fwd_mem");
      total++;
      if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin
         bad++;
         $display("FAIL fwd_mem: got %b %b expected 10 10", ForwardAE, ForwardBE);
      end
      clk_adv("fwd_mem");
      RegWriteM = 0;
      eval_comb("fwd_wb");
      total++;
      if (ForwardAE !== 2'b01) begin
         bad++;
         $display("FAIL fwd_wb: got %b expected 01", ForwardAE);
      end
      clk_adv("fwd_wb");
      RegWriteW = 0;
      eval_comb("fwd_none");
      total++;
      if (ForwardAE !== 2'b00) begin
         bad++;
         $display("FAIL fwd_none: got %b expected 00", ForwardAE);
      end
      clk_adv("fwd_none");
      clear_inputs();
   endtask

   task automatic test_timeout();
      int n;
      clear_inputs();
      n = 0;
      for (int c = 1; c <= 300; c++) begin
         MemAccessM = (c == 1);
         eval_comb("timeout");
         clk_adv("timeout");
         if (mem_timeout === 1'b1) begin n = c; break; end
      end
      total++;
      if (n != int'(TIMEOUT) + 1) begin
         bad++;
         $display("FAIL timeout_latency: got %0d expected %0d", n, TIMEOUT + 1);
      end
      // ERR holds even when an ack or new access shows up
      for (int c = 0; c < 3; c++) begin
         dmem_ack = 1; MemAccessM = 1;
         eval_comb("err_hold");
         total++;
         if (StallF !== 1'b1 || dmem_req !== 1'b0 || mem_timeout !== 1'b1) begin
            bad++;
            $display("FAIL err_hold: got stallF=%b req=%b to=%b expected 1 0 1",
                     StallF, dmem_req, mem_timeout);
         end
         clk_adv("err_hold");
      end
      clear_inputs();
      rst_n = 0;
      eval_comb("err_reset");
      clk_adv("err_reset");
      rst_n = 1;
      eval_comb("err_recover");
      total++;
      if (mem_timeout !== 1'b0 || StallF !== 1'b0 || dmem_req !== 1'b0) begin
         bad++;
         $display("FAIL err_recover: got to=%b stallF=%b req=%b expected 0 0 0",
                  mem_timeout, StallF, dmem_req);
      end
      clk_adv("err_recover");
   endtask

   task automatic test_reset_in_wait();
      clear_inputs();
      MemAccessM = 1;
      eval_comb("rst_wait_start");
      clk_adv("rst_wait_start");
      MemAccessM = 0;
      eval_comb("rst_wait_hold");
      clk_adv("rst_wait_hold");
      rst_n = 0;
      eval_comb("rst_wait_rst");
      clk_adv("rst_wait_rst");
      rst_n = 1;
      eval_comb("rst_wait_after");
      total++;
      if (dmem_req !== 1'b0 || StallF !== 1'b0) begin
         bad++;
         $display("FAIL rst_wait_after: got req=%b stallF=%b expected 0 0", dmem_req, StallF);
      end
      clk_adv("rst_wait_after");
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         rst_n       = ($urandom_range(0, 99) != 0);
         MemAccessM  = 1'($urandom_range(0, 1));
         dmem_ack    = ($urandom_range(0, 3) == 0);
         ResultSrcE0 = 1'($urandom_range(0, 1));
         PCSrcE      = ($urandom_range(0, 3) == 0);
         RegWriteM   = 1'($urandom_range(0, 1));
         RegWriteW   = 1'($urandom_range(0, 1));
         Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
         RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
         RdW  = 5'($urandom_range(0, 3));
         eval_comb("random");
         clk_adv("random");
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst_n = 0;
      @(negedge clk);
      test_reset();
      test_same_cycle_ack();
      test_mem_wait3();
      test_lw_stall();
      test_branch_in_wait();
      test_forward();
      test_reset_in_wait();
      test_timeout();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pl_hazard_ctrl.md
PL_HAZARD_CTRL -- requirements
Module: pl_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum cycles in WAIT before the block raises a timeout.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 Rs1D, Rs2D  input  5  source register numbers in Decode.
REQ-005 Rs1E, Rs2E, RdE  input  5  source and destination register numbers in Execute.
REQ-006 ResultSrcE0  input  1  high when the instruction in Execute is a load.
REQ-007 PCSrcE  input  1  branch or jump taken, resolved in Execute.
REQ-008 RdM, RdW  input  5  destination register numbers in Memory and Writeback.
REQ-009 RegWriteM, RegWriteW  input  1  register-write enables in Memory and Writeback.
REQ-010 MemAccessM  input  1  high when the instruction in Memory is a load or a store.
REQ-011 dmem_ack  input  1  data-memory completion strobe.
REQ-012 dmem_req  output  1  data-memory request.
REQ-013 ForwardAE, ForwardBE  output  2  operand forwarding selects: 00 register file, 01 Writeback, 10 Memory.
REQ-014 StallF, StallD, StallE, StallM, StallW  output  1  hold enables for the PC register and for the D, E, M and W pipeline registers; 1 means hold.
REQ-015 FlushD, FlushE, FlushW  output  1  synchronous clears for the D, E and W pipeline registers.
REQ-016 mem_timeout  output  1  sticky error flag.
REQ-017 stall_cycles  output  16  saturating count of stalled cycles.

Function
REQ-018 The block SHALL use three FSM states: IDLE, WAIT and ERR.
REQ-019 In IDLE, dmem_req SHALL equal MemAccessM; in WAIT, dmem_req SHALL be 1; in ERR, dmem_req SHALL be 0.
REQ-020 mem_busy SHALL be (dmem_req AND NOT dmem_ack), or state==ERR.
REQ-021 IDLE transitions: to WAIT when MemAccessM=1 and dmem_ack=0; otherwise stay in IDLE. An ack in the same cycle SHALL cost zero stall cycles.
REQ-022 WAIT transitions: to IDLE on dmem_ack=1; to ERR when the wait counter reaches TIMEOUT_CYC with no ack; otherwise stay in WAIT.
REQ-023 The wait counter SHALL clear on entry to WAIT and increment once per WAIT cycle.
REQ-024 ERR SHALL be absorbing until reset, and mem_timeout SHALL be 1 in ERR.
REQ-025 While mem_busy: StallF=StallD=StallE=StallM=1, StallW=0 and FlushW=1, so a bubble enters Writeback; FlushD=FlushE=0.
REQ-026 lwStall SHALL be ResultSrcE0 AND RdE!=0 AND (RdE==Rs1D OR RdE==Rs2D).
REQ-027 When not mem_busy and lwStall=1: StallF=StallD=1 and FlushE=1.
REQ-028 When not mem_busy and PCSrcE=1: FlushD=1 and FlushE=1; PCSrcE together with lwStall SHALL assert FlushD, FlushE, StallF and StallD.
REQ-029 mem_busy SHALL mask both lwStall and PCSrcE; the masked event SHALL be re-evaluated each cycle, because the E and D registers are held.
REQ-030 Stall and flush outputs not otherwise asserted SHALL be 0.
REQ-031 ForwardAE SHALL be 10 if RegWriteM=1, RdM!=0 and RdM==Rs1E.
REQ-032 Otherwise ForwardAE SHALL be 01 if RegWriteW=1, RdW!=0 and RdW==Rs1E; otherwise 00. Memory SHALL take priority over Writeback.
REQ-033 ForwardBE SHALL follow the same rules as ForwardAE, using Rs2E.
REQ-034 Forwarding, stall, flush and dmem_req outputs SHALL be combinational from the inputs and the current state; zero added latency.
REQ-035 stall_cycles SHALL increment on each cycle with StallF=1 and saturate at 0xFFFF.

Reset
REQ-036 When rst_n=0 at a clock edge, the block SHALL set state=IDLE, wait counter=0, mem_timeout=0 and stall_cycles=0.
REQ-037 While rst_n=0, the block SHALL drive dmem_req=0, all Stall*=0, FlushD=FlushE=FlushW=1 and Forward*=00.
REQ-038 Reset asserted during WAIT or ERR SHALL abandon the access, with no request issued on the following cycle.

Verification
REQ-039 Bench SHALL cover: MemAccessM=1 with dmem_ack=1 in the same cycle -> dmem_req=1, no stall, state stays IDLE.
REQ-040 Bench SHALL cover: MemAccessM=1 with ack after 3 cycles -> StallF/D/E/M=1 and FlushW=1 for exactly 3 cycles, stall_cycles=3, return to IDLE.
REQ-041 Bench SHALL cover: load in E with RdE=5 and Rs2D=5 -> StallF=StallD=FlushE=1 for one cycle; the same case with RdE=0 -> no stall.
REQ-042 Bench SHALL cover: PCSrcE=1 during a WAIT cycle -> FlushD=FlushE=0 until the ack, then FlushD=FlushE=1.
REQ-043 Bench SHALL cover: RdM=RdW=Rs1E=7 with both write enables set -> ForwardAE=10; RegWriteM=0 -> ForwardAE=01.
REQ-044 Bench SHALL cover: no ack for 255 WAIT cycles -> ERR, mem_timeout=1 and permanent stall; rst_n=0 for one cycle -> IDLE with mem_timeout=0.
